// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (8 data bits, LSB first) with parity/stop checks and a receive FIFO
module uart_rx #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        tx_loop,
  input  logic        loopback,
  input  logic [31:0] delitel,
  input  logic [2:0]  parity_bit_mode,
  input  logic        stop_bit_num,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        err_rx,
  output logic        err_rx_dropped,
  output logic        err_stop
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;
  state_t         state_q, state_d;
  logic           sync1_q, sync1_d, s_rx, s_rx_d, s_prev, s_prev_d;
  logic [31:0]    div_q, div_d, bcnt_q, bcnt_d;
  logic [2:0]     mode_q, mode_d, nbit_q, nbit_d;
  logic           two_q, two_d, perr_q, perr_d, ferr_q, ferr_d;
  logic [7:0]     sh_q, sh_d;
  logic           err_rx_d, err_rx_dropped_d, err_stop_d;
  logic [7:0]     mem_q [FIFO_DEPTH], mem_d [FIFO_DEPTH];
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           smp, fin, good, push, pop, full, exp_par;
  assign rx_valid = cnt_q != '0;
  assign rx_data  = mem_q[rd_q];
  assign full     = cnt_q == CW'(FIFO_DEPTH);
  assign pop      = rx_valid & rx_ready;
  assign smp      = bcnt_q == div_q - 32'd1;
  assign exp_par  = mode_q == 3'd1 ? ^sh_q : mode_q == 3'd2 ? ~^sh_q : mode_q == 3'd3;
  always_comb begin
    sync1_d          = loopback ? tx_loop : rxd;
    s_rx_d           = sync1_q;
    s_prev_d         = s_rx;
    state_d          = state_q;
    div_d            = div_q;
    mode_d           = mode_q;
    two_d            = two_q;
    nbit_d           = nbit_q;
    perr_d           = perr_q;
    ferr_d           = ferr_q;
    sh_d             = sh_q;
    bcnt_d           = state_q == IDLE ? bcnt_q : smp ? 32'd0 : bcnt_q + 32'd1;
    fin              = 1'b0;
    case (state_q)
      IDLE: if (s_prev & ~s_rx) begin
        div_d   = delitel < 32'd2 ? 32'd2 : delitel;
        mode_d  = parity_bit_mode;
        two_d   = stop_bit_num;
        bcnt_d  = div_d >> 1;
        nbit_d  = 3'd0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
        state_d = START;
      end
      START: if (smp) state_d = s_rx ? IDLE : DATA;
      DATA: if (smp) begin
        sh_d   = {s_rx, sh_q[7:1]};
        nbit_d = nbit_q + 3'd1;
        if (nbit_q == 3'd7) state_d = (mode_q >= 3'd1 && mode_q <= 3'd4) ? PARITY : STOP1;
      end
      PARITY: if (smp) begin
        perr_d  = s_rx != exp_par;
        state_d = STOP1;
      end
      STOP1: if (smp) begin
        ferr_d  = ~s_rx;
        state_d = two_q ? STOP2 : IDLE;
        fin     = ~two_q;
      end
      STOP2: if (smp) begin
        ferr_d  = ferr_q | ~s_rx;
        state_d = IDLE;
        fin     = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // frame outcome is decided in the final sample cycle and lands one edge later
    good             = fin & ~ferr_d & ~perr_q;
    push             = good & (~full | pop);
    err_stop_d       = fin & ferr_d;
    err_rx_d         = fin & perr_q;
    err_rx_dropped_d = good & full & ~pop;
    mem_d            = mem_q;
    if (push) mem_d[wr_q] = sh_q;
    wr_d             = wr_q + AW'(push);
    rd_d             = rd_q + AW'(pop);
    cnt_d            = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync1_q        <= 1'b1;
      s_rx           <= 1'b1;
      s_prev         <= 1'b1;
      state_q        <= IDLE;
      div_q          <= 32'd2;
      bcnt_q         <= '0;
      mode_q         <= '0;
      two_q          <= 1'b0;
      nbit_q         <= '0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
      sh_q           <= '0;
      err_rx         <= 1'b0;
      err_rx_dropped <= 1'b0;
      err_stop       <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q           <= '0;
      rd_q           <= '0;
      cnt_q          <= '0;
    end else begin
      sync1_q        <= sync1_d;
      s_rx           <= s_rx_d;
      s_prev         <= s_prev_d;
      state_q        <= state_d;
      div_q          <= div_d;
      bcnt_q         <= bcnt_d;
      mode_q         <= mode_d;
      two_q          <= two_d;
      nbit_q         <= nbit_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
      sh_q           <= sh_d;
      err_rx         <= err_rx_d;
      err_rx_dropped <= err_rx_dropped_d;
      err_stop       <= err_stop_d;
      mem_q          <= mem_d;
      wr_q           <= wr_d;
      rd_q           <= rd_d;
      cnt_q          <= cnt_d;
    end
endmodule
